aon_key_reg_wr_ctrl: RTL and testbench

AON_KEY_REG_WR_CTRL -- requirements
Module: aon_key_reg_wr_ctrl

---
 rtl/aon_key_reg_pkg.sv | 15 +
 rtl/aon_key_reg_wr_ctrl_if.sv | 28 ++
 rtl/aon_key_unlock_tmr.sv | 39 +++
 rtl/aon_key_reg_wr_ctrl.sv | 114 +++++++++++
 tb/tb_aon_key_reg_wr_ctrl.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aon_key_reg_pkg.sv
// Shared types and defaults for the key-protected register write controller.
package aon_key_reg_pkg;

  localparam int unsigned      DEF_WIDTH   = 20;
  localparam logic [31:0]      DEF_KEY     = 32'h0051F15E;
  localparam int unsigned      TMR_W       = 8;
  localparam logic [TMR_W-1:0] DEF_TIMEOUT = 8'd255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/aon_key_reg_wr_ctrl_if.sv
// Request/response bus of aon_key_reg_wr_ctrl; master = requester, slave = controller.
interface aon_key_reg_wr_ctrl_if
  import aon_key_reg_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic             io_req_valid;
  logic             io_req_ready;
  logic             io_req_is_key;
  logic [31:0]      io_req_data;
  logic [WIDTH-1:0] io_req_mask;
  logic             io_resp_valid;
  logic             io_resp_ready;
  logic             io_resp_err;
  logic [WIDTH-1:0] io_resp_rdata;

  modport master (
    output io_req_valid, io_req_is_key, io_req_data, io_req_mask, io_resp_ready,
    input  io_req_ready, io_resp_valid, io_resp_err, io_resp_rdata
  );

  modport slave (
    input  io_req_valid, io_req_is_key, io_req_data, io_req_mask, io_resp_ready,
    output io_req_ready, io_resp_valid, io_resp_err, io_resp_rdata
  );

endinterface

// File: rtl/aon_key_unlock_tmr.sv
// Unlock expiry timer; only built when AON_KEY_REG_WR_TIMEOUT_EN is defined.
`ifdef AON_KEY_REG_WR_TIMEOUT_EN
module aon_key_unlock_tmr
  import aon_key_reg_pkg::*;
#(
  parameter logic [TMR_W-1:0] TIMEOUT_CYC = DEF_TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic count_en,
  input  logic clear,
  output logic expire
);

  localparam logic [TMR_W-1:0] LAST = TIMEOUT_CYC - TMR_W'(1);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  // Expiry fires on the idle cycle that brings the count to TIMEOUT_CYC.
  always_comb begin
    expire = count_en && (cnt_q == LAST);
    cnt_d  = cnt_q;
    if (clear || expire) begin
      cnt_d = '0;
    end else if (count_en) begin
      cnt_d = cnt_q + TMR_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/aon_key_reg_wr_ctrl.sv
// Key-protected write controller for an external register vector.
// Optional unlock expiry: define AON_KEY_REG_WR_TIMEOUT_EN.
module aon_key_reg_wr_ctrl
  import aon_key_reg_pkg::*;
#(
  parameter int unsigned      WIDTH       = DEF_WIDTH,
  parameter logic [31:0]      KEY         = DEF_KEY,
  parameter logic [TMR_W-1:0] TIMEOUT_CYC = DEF_TIMEOUT
) (
  input  logic                 clock,
  input  logic                 reset,
  aon_key_reg_wr_ctrl_if.slave bus,
  input  logic [WIDTH-1:0]     io_q,
  output logic [WIDTH-1:0]     io_d,
  output logic                 io_en,
  output logic                 io_unlocked
);

  state_e           state_q, state_d;
  logic             unlocked_q, unlocked_d;
  logic             err_q, err_d;
  logic             en_q, en_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             accept;
  logic             key_ok;
  logic             expire;

  always_comb begin
    accept = bus.io_req_valid && (state_q == ST_IDLE);
    key_ok = (bus.io_req_data == KEY);
  end

`ifdef AON_KEY_REG_WR_TIMEOUT_EN
  logic tmr_count_en;

  always_comb tmr_count_en = unlocked_q && (state_q == ST_IDLE) && !bus.io_req_valid;

  aon_key_unlock_tmr #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_unlock_tmr (
    .clock    (clock),
    .reset    (reset),
    .count_en (tmr_count_en),
    .clear    (accept),
    .expire   (expire)
  );
`else
  logic unused_timeout;

  always_comb begin
    expire         = 1'b0;
    unused_timeout = ^TIMEOUT_CYC;
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      unlocked_q <= 1'b0;
      err_q      <= 1'b0;
      en_q       <= 1'b0;
      d_q        <= '0;
    end else begin
      state_q    <= state_d;
      unlocked_q <= unlocked_d;
      err_q      <= err_d;
      en_q       <= en_d;
      d_q        <= d_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = (bus.io_req_is_key || !unlocked_q) ? ST_RESP : ST_WRITE;
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  if (bus.io_resp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Merge is computed from io_q at accept time; io_d is held until the next write.
  always_comb begin
    unlocked_d = unlocked_q;
    err_d      = err_q;
    d_d        = d_q;
    if (accept) begin
      if (bus.io_req_is_key) begin
        unlocked_d = key_ok;
        err_d      = !key_ok;
      end else if (unlocked_q) begin
        unlocked_d = 1'b0;
        err_d      = 1'b0;
        d_d        = (io_q & ~bus.io_req_mask) | (bus.io_req_data[WIDTH-1:0] & bus.io_req_mask);
      end else begin
        err_d      = 1'b1;
      end
    end else if (expire) begin
      unlocked_d = 1'b0;
    end
    en_d = (state_d == ST_WRITE);
  end

  always_comb begin
    bus.io_req_ready  = (state_q == ST_IDLE);
    bus.io_resp_valid = (state_q == ST_RESP);
    bus.io_resp_err   = err_q;
    bus.io_resp_rdata = io_q;
    io_en             = en_q;
    io_d              = d_q;
    io_unlocked       = unlocked_q;
  end

endmodule

// File: tb/tb_aon_key_reg_wr_ctrl.sv
// Scoreboard bench for aon_key_reg_wr_ctrl; timeout tests run when AON_KEY_REG_WR_TIMEOUT_EN is defined.
module tb_aon_key_reg_wr_ctrl;

  localparam int unsigned W    = 20;
  localparam logic [31:0] KEYV = 32'h0051F15E;
`ifdef AON_KEY_REG_WR_TIMEOUT_EN
  localparam logic [7:0]  TMO  = 8'd4;
`else
  localparam logic [7:0]  TMO  = 8'd255;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] io_q, io_d, dreg, pre_val;
  logic         io_en, io_unlocked, pre_en;

  always #5 clk = ~clk;

  aon_key_reg_wr_ctrl_if #(.WIDTH(W)) bus ();

  aon_key_reg_wr_ctrl #(
    .WIDTH       (W),
    .KEY         (KEYV),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clock       (clk),
    .reset       (rst),
    .bus         (bus),
    .io_q        (io_q),
    .io_d        (io_d),
    .io_en       (io_en),
    .io_unlocked (io_unlocked)
  );

  // Downstream register vector, with a bench-side preset path.
  always @(posedge clk) begin
    if (io_en) dreg <= io_d;
    else if (pre_en) dreg <= pre_val;
  end
  assign io_q = dreg;

  typedef struct {
    int           first_cyc;
    bit           seen;
    logic         err;
    logic [W-1:0] rdata;
    logic         unl;
  } resp_t;

  typedef struct {
    int           cyc;
    logic [W-1:0] d;
  } en_t;

  resp_t        rq[$];
  en_t          eq[$];
  int           vectors = 0;
  int           miscompares = 0;
  int           cyc = 0;
  int           rdy_mode = 1;
  bit           mon_en = 1'b0;
  bit           mdl_unl = 1'b0;
  logic [W-1:0] mdl_reg = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial begin
    bus.io_resp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.io_resp_ready = ($urandom_range(0, 2) != 0);
        1:       bus.io_resp_ready = 1'b1;
        default: bus.io_resp_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops expectations whenever the DUT presents io_en or a response.
  always @(negedge clk) begin
    resp_t r;
    en_t   e;
    if (mon_en && !rst) begin
      if (io_en) begin
        if (eq.size() == 0) chk("spurious_en", io_en, 1'b0);
        else begin
          e = eq.pop_front();
          chk("en_cycle", cyc, e.cyc);
          chk("io_d", io_d, e.d);
        end
      end
      if (bus.io_resp_valid) begin
        if (rq.size() == 0) chk("spurious_resp", bus.io_resp_valid, 1'b0);
        else begin
          r = rq[0];
          if (!r.seen) begin
            chk("resp_latency", cyc, r.first_cyc);
            rq[0].seen = 1'b1;
          end
          chk("resp_err", bus.io_resp_err, r.err);
          chk("resp_rdata", bus.io_resp_rdata, r.rdata);
          chk("req_ready_in_resp", bus.io_req_ready, 1'b0);
          if (bus.io_resp_ready) begin
            chk("unlocked", io_unlocked, r.unl);
            void'(rq.pop_front());
          end
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic issue(input bit k, input logic [31:0] data, input logic [W-1:0] mask);
    int           waitc = 0;
    resp_t        r;
    en_t          e;
    logic [W-1:0] nv;
    bus.io_req_valid  = 1'b1;
    bus.io_req_is_key = k;
    bus.io_req_data   = data;
    bus.io_req_mask   = mask;
    while (!bus.io_req_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (!bus.io_req_ready) begin
      chk("req_ready_wait", bus.io_req_ready, 1'b1);
      bus.io_req_valid = 1'b0;
      return;
    end
    r.seen      = 1'b0;
    r.first_cyc = cyc + 1;
    if (k) begin
      mdl_unl = (data == KEYV);
      r.err   = !mdl_unl;
    end else if (mdl_unl) begin
      nv          = (mdl_reg & ~mask) | (data[W-1:0] & mask);
      mdl_reg     = nv;
      mdl_unl     = 1'b0;
      r.err       = 1'b0;
      r.first_cyc = cyc + 2;
      e.cyc       = cyc + 1;
      e.d         = nv;
      eq.push_back(e);
    end else begin
      r.err = 1'b1;
    end
    r.rdata = mdl_reg;
    r.unl   = mdl_unl;
    rq.push_back(r);
    @(negedge clk);
    bus.io_req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.io_req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic preset(input logic [W-1:0] v);
    pre_val = v;
    pre_en  = 1'b1;
    @(negedge clk);
    pre_en  = 1'b0;
    mdl_reg = v;
  endtask

  task automatic check_reset_state();
    chk("rst_io_en", io_en, 1'b0);
    chk("rst_io_d", io_d, '0);
    chk("rst_resp_valid", bus.io_resp_valid, 1'b0);
    chk("rst_resp_err", bus.io_resp_err, 1'b0);
    chk("rst_unlocked", io_unlocked, 1'b0);
    chk("rst_req_ready", bus.io_req_ready, 1'b1);
  endtask

  initial begin
    int           n;
    logic [31:0]  kd;
    logic [W-1:0] mk;
    bus.io_req_valid  = 1'b0;
    bus.io_req_is_key = 1'b0;
    bus.io_req_data   = '0;
    bus.io_req_mask   = '0;
    pre_en            = 1'b0;
    pre_val           = '0;
    @(negedge clk);
    preset('0);
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
    check_reset_state();

    // Locked write is rejected.
    issue(1'b0, 32'h000ABCDE, 20'hFFFFF);
    // Unlock then full-mask write.
    issue(1'b1, KEYV, '0);
    issue(1'b0, 32'h00012345, 20'hFFFFF);
    // Partial mask merge against an all-ones register.
    idle(2);
    preset(20'hFFFFF);
    issue(1'b1, KEYV, '0);
    issue(1'b0, 32'h00000000, 20'h000F0);
    // Wrong key, then a rejected write.
    issue(1'b1, 32'h0051F15F, '0);
    issue(1'b0, 32'h00055555, 20'hFFFFF);
    // Zero mask still pulses io_en and consumes the unlock.
    issue(1'b1, KEYV, '0);
    issue(1'b0, 32'h000AAAAA, '0);
    issue(1'b0, 32'h000AAAAA, 20'hFFFFF);
    // Re-key keeps the unlock; a bad key relocks.
    issue(1'b1, KEYV, '0);
    issue(1'b1, KEYV, '0);
    issue(1'b1, 32'h12345678, '0);
    issue(1'b0, 32'h00011111, 20'hFFFFF);

    // Response held while io_resp_ready stays low.
    rdy_mode = 2;
    idle(2);
    issue(1'b1, KEYV, '0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_resp_valid", bus.io_resp_valid, 1'b1);
      chk("stall_req_ready", bus.io_req_ready, 1'b0);
      @(negedge clk);
    end
    rdy_mode = 1;
    issue(1'b0, 32'h00033333, 20'h0FF0F);

    // Reset asserted during WRITE drops io_en at once.
    issue(1'b1, KEYV, '0);
    issue(1'b0, 32'h00077777, 20'hFFFFF);
    #2 rst = 1'b1;
    #1 chk("en_async_rst", io_en, 1'b0);
    rq.delete();
    eq.delete();
    mdl_unl = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state();
    idle(2);

`ifdef AON_KEY_REG_WR_TIMEOUT_EN
    // Unlock expires after TMO idle cycles; a write before that still lands.
    issue(1'b1, KEYV, '0);
    idle(5);
    mdl_unl = 1'b0;
    issue(1'b0, 32'h00044444, 20'hFFFFF);
    issue(1'b1, KEYV, '0);
    idle(3);
    issue(1'b0, 32'h00066666, 20'hFFFFF);
`endif

    // Randomized traffic with random response back-pressure.
    idle(2);
    preset(W'($urandom));
    rdy_mode = 0;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        kd = ($urandom_range(0, 1) == 0) ? KEYV : $urandom;
        issue(1'b1, kd, W'($urandom));
      end else begin
        case ($urandom_range(0, 3))
          0:       mk = '0;
          1:       mk = '1;
          default: mk = W'($urandom);
        endcase
        issue(1'b0, $urandom, mk);
      end
`ifndef AON_KEY_REG_WR_TIMEOUT_EN
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
`endif
    end

    rdy_mode = 1;
    idle(1);
    n = 0;
    while (rq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_resp", rq.size(), 0);
    chk("drain_en", eq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
